// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: show-ahead receive buffer that sits behind a UART receiver.
// Each rising edge of finish_in is one received word. The word is stored with
// bit 8 cleared when the link runs 8-bit words. A consumer drains the buffer
// through a valid/ready read port. A sticky overflow flag records any word
// that was dropped because the buffer was full.
//
// Read handshake: rd_valid is high whenever the buffer holds at least one word,
// and rd_data then shows the oldest word. A word is consumed at a rising clk
// edge where rd_valid && rd_ready. rd_valid never waits on rd_ready, and
// rd_ready while empty is ignored.
module uart_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 9
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     finish_in,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     word_cfg,
    input  logic                     flush,
    input  logic                     rd_ready,
    input  logic                     clr_ovf,
    output logic                     rd_valid,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // State registers
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             ovf_q,    ovf_d;
    logic             finish_prev_q;
    logic [WIDTH-1:0] mem_q [DEPTH];

    // Per-cycle events
    logic             strobe;
    logic             rd_fire;
    logic             wr_accept;
    logic             wr_en;
    logic             ovf_event;
    logic             full_w;
    logic [WIDTH-1:0] wr_word;

    assign full_w  = (count_q == CW'(DEPTH));
    assign strobe  = finish_in & ~finish_prev_q;
    assign rd_fire = rd_ready & (count_q != '0);

    // A full buffer still takes a word when a read frees a slot at the same
    // edge. The new word goes into the slot that is being vacated.
    assign wr_accept = strobe & (~full_w | rd_fire);
    assign ovf_event = strobe & full_w & ~rd_fire;
    assign wr_en     = wr_accept & ~flush;

    // Clear bit 8 when the receiver is configured for 8-bit words.
    generate
        if (WIDTH > 8) begin : g_mask
            // Apply the word-size mask to the incoming word.
            always_comb begin
                wr_word = data_in;
                if (!word_cfg) begin
                    wr_word[8] = 1'b0;
                end
            end
        end else begin : g_nomask
            logic unused_cfg;
            assign unused_cfg = word_cfg;
            assign wr_word    = data_in;
        end
    endgenerate

    // Next-state logic for the pointers, the occupancy count and the overflow flag.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;

        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (rd_fire) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (wr_accept) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            case ({wr_accept, rd_fire})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end

        // When clr_ovf and a new overflow event arrive in the same cycle, the
        // set wins. Flush does not touch the flag.
        if (ovf_event) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    // Control state. Reset is asynchronous and active-low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            ovf_q         <= 1'b0;
            finish_prev_q <= 1'b0;
        end else begin
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            ovf_q         <= ovf_d;
            finish_prev_q <= finish_in;
        end
    end

    // Storage array. It is not reset, because stale words are never visible
    // while the count is zero.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_word;
        end
    end

    assign rd_valid = (count_q != '0);
    assign rd_data  = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign full     = full_w;
    assign empty    = (count_q == '0);
    assign overflow = ovf_q;

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter: DEPTH, default 8, number of buffered words; legal values are powers of two, 2 to 64.
REQ-002 Parameter: WIDTH, default 9, stored word width; matches the receiver data_out width.
REQ-003 Port: clk  input  1  single clock; all state is updated on its rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous assert, active-low; the block is held in reset while rst=0.
REQ-005 Port: finish_in  input  1  word-complete flag from the receiver; may stay high for several cycles.
REQ-006 Port: data_in  input  WIDTH  received word; valid whenever finish_in is high.
REQ-007 Port: word_cfg  input  1  word-size config bit (1 = 9-bit words, 0 = 8-bit words).
REQ-008 Port: flush  input  1  synchronous clear of buffered contents.
REQ-009 Port: rd_ready  input  1  consumer accepts the head word.
REQ-010 Port: rd_valid  output  1  head word is available.
REQ-011 Port: rd_data  output  WIDTH  head word.
REQ-012 Port: count  output  $clog2(DEPTH)+1  number of words held.
REQ-013 Port: full / empty  output  1 each  count==DEPTH / count==0.
REQ-014 Port: overflow  output  1  sticky flag for a dropped word.
REQ-015 Port: clr_ovf  input  1  clears overflow.

Function
REQ-016 The write strobe SHALL be the rising edge of finish_in: finish_in=1 and the registered previous value finish_d=0; one strobe per received word, however long finish_in stays high.
REQ-017 On the strobe, the block SHALL store data_in with bit 8 forced to 0 when word_cfg=0; word_cfg is sampled in the strobe cycle.
REQ-018 The block SHALL be a show-ahead FIFO: rd_valid=!empty, and rd_data=mem[rd_ptr] combinationally with 0 added latency.
REQ-019 A read occurs when rd_valid && rd_ready; rd_ptr advances by 1 at that clock edge.
REQ-020 A written word SHALL appear on rd_valid/rd_data 1 cycle after the strobe edge; there is no write-to-read bypass in the same cycle.
REQ-021 Pointers are $clog2(DEPTH) bits wide and SHALL wrap from DEPTH-1 to 0; count is maintained separately and never exceeds DEPTH.
REQ-022 Strobe while full, with no read in that cycle: the word SHALL be dropped, pointers and count unchanged, overflow set to 1 at that edge.
REQ-023 Strobe while full, with a read in the same cycle: the write SHALL be accepted, count stays DEPTH, and overflow is unchanged.
REQ-024 Strobe and read in the same cycle when not full: both pointers SHALL advance and count is unchanged.
REQ-025 rd_ready while empty SHALL have no effect.
REQ-026 flush=1 SHALL zero both pointers and count at the next edge and take priority over a write and a read in the same cycle; overflow and finish_d are unaffected.
REQ-027 clr_ovf=1 SHALL clear overflow, except when an overflow event occurs in the same cycle, in which case overflow stays 1 (set wins).
REQ-028 mem contents are not reset; rd_data is don't-care while rd_valid=0.

Reset
REQ-029 While rst=0, the block SHALL asynchronously set: rd_ptr=0, wr_ptr=0, count=0, overflow=0, finish_d=0.
REQ-030 Resulting outputs in reset: rd_valid=0, empty=1, full=0, count=0, overflow=0.
REQ-031 Reset asserted mid-operation SHALL discard all buffered words immediately.
REQ-032 If finish_in=1 at the first edge after rst deasserts, that edge SHALL count as a strobe.

Verification
REQ-033 Single word: word_cfg=1; finish_in high for 3 cycles with data_in=9'h1A5 -> exactly one write; next cycle rd_valid=1, rd_data=9'h1A5, count=1.
REQ-034 8-bit mode: word_cfg=0, data_in=9'h1FF strobe -> rd_data=9'h0FF.
REQ-035 Fill and overflow (DEPTH=8): 9 strobes with data 0..8 and rd_ready=0 -> full=1, count=8, overflow=1; reads return 0..7 in order, then empty=1.
REQ-036 Full plus simultaneous read: at full, one strobe with data 9'h055 in the same cycle as rd_ready=1 -> count stays 8, overflow=0, and 9'h055 is read last.
REQ-037 Wrap: 20 strobes interleaved with reads keeping count at most 3 -> data order preserved across pointer wrap.
REQ-038 Flush and reset: flush with count=5 -> count=0, overflow unchanged; assert rst mid-stream -> all outputs reach their reset values without a clock edge.
